// File: rtl/dtag_array.sv
// N-way D-cache tag array: per-way valid bits, registered tag compare and
// L/H partitioned victim selection, with a reset-time invalidation sweep.
module dtag_array #(
    parameter int unsigned TAG_W    = 20,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned WAYS     = 4,
    parameter int unsigned LOW_WAYS = 2,
    parameter int unsigned WAY_W    = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_index,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_dom,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [WAY_W-1:0] rsp_way,
    input  logic             fill_valid,
    input  logic [IDX_W-1:0] fill_index,
    input  logic [WAY_W-1:0] fill_way,
    input  logic [TAG_W-1:0] fill_tag,
    input  logic             fill_dom,
    output logic             fill_err,
    input  logic             inv_valid,
    input  logic [IDX_W-1:0] inv_index,
    input  logic [WAY_W-1:0] inv_way,
    output logic             init_busy
);

    localparam int unsigned      SETS    = 1 << IDX_W;
    localparam logic [WAY_W-1:0] L_LAST  = WAY_W'(LOW_WAYS - 1);
    localparam logic [WAY_W-1:0] H_FIRST = WAY_W'(LOW_WAYS);
    localparam logic [WAY_W-1:0] H_LAST  = WAY_W'(WAYS - 1);
    localparam logic [WAYS-1:0]  L_MASK  = WAYS'((1 << LOW_WAYS) - 1);
    localparam logic [WAYS-1:0]  H_MASK  = ~L_MASK;

    typedef enum logic {S_INIT, S_READY} state_t;

    state_t           state;
    logic [IDX_W-1:0] sweep_idx;
    logic [WAY_W-1:0] ptr_l;
    logic [WAY_W-1:0] ptr_h;

    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]  valid_mem [SETS];

    logic [WAYS-1:0]  set_valid;
    logic [WAYS-1:0]  vis_mask;
    logic [WAYS-1:0]  own_mask;
    logic [WAYS-1:0]  match;
    logic [WAYS-1:0]  free;
    logic             lk_hit;
    logic [WAY_W-1:0] lk_hit_way;
    logic [WAY_W-1:0] lk_victim;
    logic             fill_in_low;
    logic             fill_ok;
    logic             tag_we;

    // Lookup against pre-edge contents; lowest matching / lowest free way wins.
    always_comb begin
        set_valid  = valid_mem[req_index];
        vis_mask   = req_dom ? {WAYS{1'b1}} : L_MASK;
        own_mask   = req_dom ? H_MASK : L_MASK;
        match      = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            match[w] = set_valid[w] && vis_mask[w] && (tag_mem[req_index][w] == req_tag);
        end
        free       = ~set_valid & own_mask;
        lk_hit     = |match;
        lk_hit_way = '0;
        lk_victim  = req_dom ? ptr_h : ptr_l;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (match[w]) lk_hit_way = WAY_W'(w);
            if (free[w])  lk_victim  = WAY_W'(w);
        end
    end

    assign fill_in_low = (fill_way < H_FIRST);
    assign fill_ok     = (fill_in_low == !fill_dom);
    assign tag_we      = !rst && (state == S_READY) && fill_valid && fill_ok;

    // Tag storage has no reset; only legal fills in READY write it.
    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[fill_index][fill_way] <= fill_tag;
    end

    // Sweep FSM, valid bits, replacement pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_INIT;
            sweep_idx <= '0;
            req_ready <= 1'b0;
            init_busy <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_way   <= '0;
            fill_err  <= 1'b0;
            ptr_l     <= '0;
            ptr_h     <= H_FIRST;
        end else begin
            rsp_valid <= 1'b0;
            fill_err  <= 1'b0;
            case (state)
                S_INIT: begin
                    valid_mem[sweep_idx] <= '0;
                    sweep_idx            <= sweep_idx + 1'b1;
                    if (sweep_idx == IDX_W'(SETS - 1)) begin
                        state     <= S_READY;
                        req_ready <= 1'b1;
                        init_busy <= 1'b0;
                    end
                end
                S_READY: begin
                    if (req_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= lk_hit;
                        rsp_way   <= lk_hit ? lk_hit_way : lk_victim;
                    end
                    if (fill_valid) begin
                        if (fill_ok) begin
                            valid_mem[fill_index][fill_way] <= 1'b1;
                            if (fill_in_low) ptr_l <= (ptr_l == L_LAST) ? '0 : ptr_l + 1'b1;
                            else             ptr_h <= (ptr_h == H_LAST) ? H_FIRST : ptr_h + 1'b1;
                        end else begin
                            fill_err <= 1'b1;
                        end
                    end
                    // Later assignment: invalidate beats a same-cycle fill.
                    if (inv_valid) valid_mem[inv_index][inv_way] <= 1'b0;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dtag_array.sv
// Randomized and directed bench for dtag_array, checked every cycle against
// a partition-aware behavioural cache model.
module tb_dtag_array;

    localparam int TAG_W = 20;
    localparam int IDX_W = 5;
    localparam int WAYS  = 4;
    localparam int LOW   = 2;
    localparam int WAY_W = 2;
    localparam int SETS  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic             req_dom;
    logic             rsp_valid;
    logic             rsp_hit;
    logic [WAY_W-1:0] rsp_way;
    logic             fill_valid;
    logic [IDX_W-1:0] fill_index;
    logic [WAY_W-1:0] fill_way;
    logic [TAG_W-1:0] fill_tag;
    logic             fill_dom;
    logic             fill_err;
    logic             inv_valid;
    logic [IDX_W-1:0] inv_index;
    logic [WAY_W-1:0] inv_way;
    logic             init_busy;

    dtag_array dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index),
        .req_tag(req_tag), .req_dom(req_dom),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .fill_valid(fill_valid), .fill_index(fill_index), .fill_way(fill_way),
        .fill_tag(fill_tag), .fill_dom(fill_dom), .fill_err(fill_err),
        .inv_valid(inv_valid), .inv_index(inv_index), .inv_way(inv_way),
        .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: cache contents, per-domain pointers, cycles since reset release.
    bit               mv [SETS][WAYS];
    logic [TAG_W-1:0] mt [SETS][WAYS];
    int  pl, ph, since;
    bit  e_rst = 1'b1, e_ready = 1'b0, e_busy = 1'b1, e_rv = 1'b0, e_hit = 1'b0, e_ferr = 1'b0;
    int  e_way = 0;

    task automatic model_lookup(input int idx, input logic [TAG_W-1:0] tag, input bit dom,
                                output bit hit, output int way);
        int lo, hi;
        hit = 1'b0;
        way = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && (dom || w < LOW) && mv[idx][w] && mt[idx][w] == tag) begin
                hit = 1'b1;
                way = w;
            end
        end
        if (!hit) begin
            lo = dom ? LOW : 0;
            hi = dom ? WAYS : LOW;
            for (int w = lo; w < hi; w++) if (way < 0 && !mv[idx][w]) way = w;
            if (way < 0) way = dom ? ph : pl;
        end
    endtask

    always @(posedge clk) begin
        bit rdy, legal, h;
        int w;
        if (rst) begin
            for (int s = 0; s < SETS; s++) for (int k = 0; k < WAYS; k++) mv[s][k] = 1'b0;
            pl = 0; ph = LOW; since = 0;
            e_rst = 1'b1; e_rv = 1'b0; e_hit = 1'b0; e_way = 0; e_ferr = 1'b0;
            e_ready = 1'b0; e_busy = 1'b1;
        end else begin
            e_rst = 1'b0;
            rdy   = (since >= SETS);
            e_rv  = rdy && req_valid;
            if (e_rv) begin
                model_lookup(int'(req_index), req_tag, req_dom, h, w);
                e_hit = h;
                e_way = w;
            end
            legal  = ((int'(fill_way) < LOW) == !fill_dom);
            e_ferr = rdy && fill_valid && !legal;
            if (rdy && fill_valid && legal) begin
                mt[fill_index][fill_way] = fill_tag;
                mv[fill_index][fill_way] = 1'b1;
                if (fill_dom) ph = LOW + (ph - LOW + 1) % (WAYS - LOW);
                else          pl = (pl + 1) % LOW;
            end
            if (rdy && inv_valid) mv[inv_index][inv_way] = 1'b0;
            if (since < SETS) since++;
            e_ready = (since >= SETS);
            e_busy  = !e_ready;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("init_busy", 32'(init_busy), 32'(e_busy));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
        chk("fill_err",  32'(fill_err),  32'(e_ferr));
        if (e_rv || e_rst) begin
            chk("rsp_hit", 32'(rsp_hit), 32'(e_hit));
            chk("rsp_way", 32'(rsp_way), 32'(e_way));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; fill_valid = 1'b0; inv_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic fill(input int idx, input int way, input int tag, input bit dom);
        fill_valid = 1'b1; fill_index = IDX_W'(idx); fill_way = WAY_W'(way);
        fill_tag = TAG_W'(tag); fill_dom = dom;
        step();
        fill_valid = 1'b0;
    endtask

    task automatic look(input int idx, input int tag, input bit dom, output bit h, output int w);
        req_valid = 1'b1; req_index = IDX_W'(idx); req_tag = TAG_W'(tag); req_dom = dom;
        step();
        req_valid = 1'b0;
        h = rsp_hit;
        w = int'(rsp_way);
    endtask

    initial begin
        bit h;
        int w, n, way;
        rst = 1'b1;
        req_index = '0; req_tag = '0; req_dom = 1'b0;
        fill_index = '0; fill_way = '0; fill_tag = '0; fill_dom = 1'b0;
        inv_index = '0; inv_way = '0;
        idle_inputs();
        repeat (3) step();
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_busy",  32'(init_busy), 32'd1);
        chk("reset_way",   32'(rsp_way),   32'd0);
        rst = 1'b0;
        wait_ready(n);
        chk("first_sweep_len", 32'(n), 32'd32);

        // Random traffic on a few sets with a small tag pool to force hits and conflicts.
        for (int i = 0; i < 1500; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_index  = IDX_W'($urandom_range(0, 3));
            req_tag    = TAG_W'($urandom_range(0, 5));
            req_dom    = 1'($urandom_range(0, 1));
            fill_valid = ($urandom_range(0, 1) != 0);
            fill_index = IDX_W'($urandom_range(0, 3));
            way        = int'($urandom_range(0, WAYS - 1));
            fill_way   = WAY_W'(way);
            fill_tag   = TAG_W'($urandom_range(0, 5));
            fill_dom   = (way >= LOW) ^ ($urandom_range(0, 7) == 0);
            inv_valid  = ($urandom_range(0, 3) == 0);
            inv_index  = IDX_W'($urandom_range(0, 3));
            inv_way    = WAY_W'($urandom_range(0, WAYS - 1));
            step();
        end

        // Sweep after populated array: everything must miss.
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n);
        chk("sweep_len", 32'(n), 32'd32);
        for (int s = 0; s < SETS; s++) begin
            look(s, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), h, w);
            chk("sweep_miss", 32'(h), 32'd0);
        end

        // Fill then lookup.
        fill(3, 1, 'h0ABCD, 1'b0);
        chk("model_valid_3_1", 32'(mv[3][1]), 32'd1);
        chk("model_tag_3_1", 32'(mt[3][1]), 32'h0ABCD);
        look(3, 'h0ABCD, 1'b0, h, w);
        chk("fl_l_hit", 32'(h), 32'd1);
        chk("fl_l_way", 32'(w), 32'd1);
        look(3, 'h0ABCD, 1'b1, h, w);
        chk("fl_h_hit", 32'(h), 32'd1);
        chk("fl_h_way", 32'(w), 32'd1);
        look(3, 'h0ABCE, 1'b0, h, w);
        chk("fl_miss_hit", 32'(h), 32'd0);
        chk("fl_miss_way", 32'(w), 32'd0);

        // Partition isolation and illegal fill.
        fill(5, 2, 'h12345, 1'b1);
        look(5, 'h12345, 1'b0, h, w);
        chk("iso_l_hit", 32'(h), 32'd0);
        chk("iso_l_victim_low", 32'(w <= 1), 32'd1);
        look(5, 'h12345, 1'b1, h, w);
        chk("iso_h_hit", 32'(h), 32'd1);
        chk("iso_h_way", 32'(w), 32'd2);
        fill(5, 2, 'h55555, 1'b0);
        chk("iso_fill_err", 32'(fill_err), 32'd1);
        look(5, 'h12345, 1'b1, h, w);
        chk("iso_unchanged", 32'(h), 32'd1);

        // Round-robin from fresh reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n);
        chk("rr_sweep_len", 32'(n), 32'd32);
        for (int k = 0; k < WAYS; k++) fill(7, k, 'h70 + k, k >= LOW);
        for (int k = 0; k < 4; k++) begin
            look(7, 'h7F0 + k, 1'b1, h, w);
            chk("rr_hit", 32'(h), 32'd0);
            chk("rr_victim", 32'(w), (k % 2 == 1) ? 32'd3 : 32'd2);
            fill(7, w, 'h7F0 + k, 1'b1);
        end
        look(7, 'h999, 1'b0, h, w);
        chk("rr_l_victim", 32'(w), 32'd0);

        // Same-cycle fill, invalidate and lookup on set 9 way 0.
        fill(9, 0, 'h99, 1'b0);
        fill_valid = 1'b1; fill_index = 5'd9; fill_way = 2'd0; fill_tag = 20'h99; fill_dom = 1'b0;
        inv_valid = 1'b1; inv_index = 5'd9; inv_way = 2'd0;
        look(9, 'h99, 1'b0, h, w);
        idle_inputs();
        chk("col_old_hit", 32'(h), 32'd1);
        chk("col_old_way", 32'(w), 32'd0);
        look(9, 'h99, 1'b0, h, w);
        chk("col_next_hit", 32'(h), 32'd0);
        chk("col_next_way", 32'(w), 32'd0);

        // Mid-sweep reset restarts the full sweep.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n);
        chk("midsweep_len", 32'(n), 32'd32);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
